// File: rtl/gpr_bank_if.sv
// gpr_bank_if -- signal bundle for the gpr_bank register file.
//
// Carries the operation request (op, wr_sel, data_in), the read-port
// selects (read_bus, bus_sel, mux_sel) and the status/data returned by the
// bank (MUX, zero, valid, wrap). The tri-state BUS_OUT stays a plain port
// of gpr_bank so that its high-Z state can be resolved on an ordinary net.
//
// Modports:
//   master : requester side (drives op/selects/data, observes results)
//   slave  : register bank side
interface gpr_bank_if #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
);
    localparam int SELW = $clog2(DEPTH);

    logic [1:0]       op;
    logic [SELW-1:0]  wr_sel;
    logic [WIDTH-1:0] data_in;
    logic             read_bus;
    logic [SELW-1:0]  bus_sel;
    logic [SELW-1:0]  mux_sel;
    logic [WIDTH-1:0] MUX;
    logic             zero;
    logic [DEPTH-1:0] valid;
    logic             wrap;

    modport master (
        output op, wr_sel, data_in, read_bus, bus_sel, mux_sel,
        input  MUX, zero, valid, wrap
    );

    modport slave (
        input  op, wr_sel, data_in, read_bus, bus_sel, mux_sel,
        output MUX, zero, valid, wrap
    );
endinterface

// File: rtl/gpr_bank.sv
// gpr_bank -- small general-purpose register file with LOAD/INC/DEC ops.
//
// DEPTH registers of WIDTH bits. One op per cycle on register wr_sel:
// 00 NOP, 01 LOAD data_in, 10 INC, 11 DEC (modulo 2^WIDTH). Two read
// ports: MUX (always driven, selected by mux_sel, with a zero flag) and
// BUS_OUT (tri-state, driven only while read_bus is high). Reads are
// combinational from the register array, so a register written on an edge
// reads its old value until that edge has passed.
//
// Out-of-range selects (>= DEPTH) suppress writes and read back as 0.
//
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (registers, valid, wrap -> 0)
//   bus     : gpr_bank_if.slave (op, selects, data_in, MUX, zero, valid, wrap)
//   BUS_OUT : tri-state read bus
//
// Configuration macro:
//   GPR_BANK_INCDEC_EN : when defined, INC/DEC are implemented and wrap
//                        pulses on wrap-around; when undefined, INC/DEC act
//                        as NOP and wrap is held at 0.
module gpr_bank #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    gpr_bank_if.slave        bus,
    output wire [WIDTH-1:0]  BUS_OUT
);
    localparam int SELW = $clog2(DEPTH);

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    logic [DEPTH-1:0][WIDTH-1:0] regs_r;
    logic [DEPTH-1:0]            valid_r;

    logic [WIDTH-1:0] cur_s;
    logic             hit_s;
    logic             we_s;
    logic [WIDTH-1:0] next_val_s;
    logic             wrap_nxt_s;
    logic [WIDTH-1:0] mux_val_s;
    logic [WIDTH-1:0] bus_val_s;

    // Select a register; selects with no matching register return 0.
    function automatic logic [WIDTH-1:0] pick(
        input logic [DEPTH-1:0][WIDTH-1:0] arr,
        input logic [SELW-1:0]             sel
    );
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == SELW'(i)) begin
                r = arr[i];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // True when the select addresses an existing register.
    function automatic logic in_range(input logic [SELW-1:0] sel);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == SELW'(i)) begin
                ok = 1'b1;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    assign cur_s = pick(regs_r, bus.wr_sel);
    assign hit_s = in_range(bus.wr_sel);

    // Decode the op into a write enable, the value to write and the wrap flag.
    always_comb begin
        we_s       = 1'b0;
        next_val_s = cur_s;
        wrap_nxt_s = 1'b0;
        case (bus.op)
            OP_LOAD: begin
                we_s       = hit_s;
                next_val_s = bus.data_in;
            end
`ifdef GPR_BANK_INCDEC_EN
            OP_INC: begin
                we_s       = hit_s;
                next_val_s = cur_s + WIDTH'(1);
                wrap_nxt_s = hit_s & (cur_s == {WIDTH{1'b1}});
            end
            OP_DEC: begin
                we_s       = hit_s;
                next_val_s = cur_s - WIDTH'(1);
                wrap_nxt_s = hit_s & (cur_s == {WIDTH{1'b0}});
            end
`endif
            default: begin
                we_s       = 1'b0;
                next_val_s = cur_s;
                wrap_nxt_s = 1'b0;
            end
        endcase
    end

    // Register array and written-since-reset flags; only wr_sel may change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_r  <= '0;
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we_s && (bus.wr_sel == SELW'(i))) begin
                    regs_r[i]  <= next_val_s;
                    valid_r[i] <= 1'b1;
                end else begin
                    regs_r[i]  <= regs_r[i];
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

`ifdef GPR_BANK_INCDEC_EN
    logic wrap_r;

    // One-cycle wrap pulse; any non-wrapping cycle (including NOP) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_nxt_s;
        end
    end

    assign bus.wrap = wrap_r;
`else
    assign bus.wrap = 1'b0;
`endif

    assign mux_val_s = pick(regs_r, bus.mux_sel);
    assign bus_val_s = pick(regs_r, bus.bus_sel);

    assign bus.MUX   = mux_val_s;
    assign bus.zero  = (mux_val_s == {WIDTH{1'b0}});
    assign bus.valid = valid_r;

    // The bus driver is controlled only by read_bus; during reset the
    // registers are 0, so an enabled bus reads 0 rather than floating.
    assign BUS_OUT = bus.read_bus ? bus_val_s : {WIDTH{1'bz}};
endmodule

// File: tb/tb_gpr_bank.sv
module tb_gpr_bank;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gpr_bank_if #(.WIDTH(24), .DEPTH(4)) ifa ();
    gpr_bank_if #(.WIDTH(24), .DEPTH(3)) ifb ();

    // Pulled-up nets: an undriven bus reads all ones.
    tri1 [23:0] bus_a;
    tri1 [23:0] bus_b;

    gpr_bank #(.WIDTH(24), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .bus(ifa.slave), .BUS_OUT(bus_a)
    );

    gpr_bank #(.WIDTH(24), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(ifb.slave), .BUS_OUT(bus_b)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [23:0] val;
        logic [3:0]  valid;
        logic        wrap;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [23:0] m_regs[4];
    logic [3:0]  m_valid;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 24'h0;
        m_valid = 4'b0000;
        sbq.delete();
    endtask

    // Drive one op for one cycle, update the model and queue what the bank must show afterwards.
    task automatic drive_op(input logic [1:0] o, input logic [1:0] s, input logic [23:0] d);
        exp_t e;
        logic w;
        @(negedge clk);
        ifa.op = o; ifa.wr_sel = s; ifa.data_in = d;
        w = 1'b0;
        case (o)
            2'b01: begin m_regs[s] = d; m_valid[s] = 1'b1; end
`ifdef GPR_BANK_INCDEC_EN
            2'b10: begin w = (m_regs[s] == 24'hFFFFFF); m_regs[s] = m_regs[s] + 24'h1; m_valid[s] = 1'b1; end
            2'b11: begin w = (m_regs[s] == 24'h000000); m_regs[s] = m_regs[s] - 24'h1; m_valid[s] = 1'b1; end
`endif
            default: ;
        endcase
        e.sel = s; e.val = m_regs[s]; e.valid = m_valid; e.wrap = w;
        sbq.push_back(e);
        @(posedge clk); #1;
        ifa.op = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.op = 2'b00; ifa.wr_sel = 2'd0; ifa.data_in = 24'h0;
        ifa.read_bus = 1'b1; ifa.bus_sel = 2'd0; ifa.mux_sel = 2'd0;
        ifb.op = 2'b00; ifb.wr_sel = 2'd0; ifb.data_in = 24'h0;
        ifb.read_bus = 1'b0; ifb.bus_sel = 2'd0; ifb.mux_sel = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            ifa.mux_sel = 2'(s); #1;
            total++;
            if (ifa.MUX !== 24'h0 || ifa.zero !== 1'b1) begin
                bad++;
                $display("FAIL reset_mux sel=%0d: MUX=%h zero=%b, want 000000 1", s, ifa.MUX, ifa.zero);
            end
        end
        total++;
        if (ifa.valid !== 4'b0000 || ifa.wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: valid=%b wrap=%b, want 0000 0", ifa.valid, ifa.wrap);
        end
        total++;
        if (bus_a !== 24'h0) begin
            bad++;
            $display("FAIL reset_bus: BUS_OUT=%h, want 000000", bus_a);
        end
        ifa.read_bus = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        exp_t e;
        drive_op(2'b01, 2'd2, 24'h00ABCD);
        e = sbq.pop_front(); ifa.mux_sel = e.sel; #1;
        total++;
        if (ifa.MUX !== 24'h00ABCD || ifa.valid !== 4'b0100 || ifa.zero !== 1'b0 || ifa.MUX !== e.val) begin
            bad++;
            $display("FAIL load: MUX=%h valid=%b zero=%b, want 00abcd 0100 0", ifa.MUX, ifa.valid, ifa.zero);
        end
    endtask

    task automatic test_incdec();
        exp_t e;
        logic [1:0] ops[4] = '{2'b01, 2'b10, 2'b00, 2'b11};
        logic [1:0] sels[4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], sels[i], 24'hFFFFFF);
            e = sbq.pop_front(); ifa.mux_sel = e.sel; #1;
            total++;
            if (ifa.MUX !== e.val || ifa.valid !== e.valid || ifa.wrap !== e.wrap ||
                ifa.zero !== (e.val == 24'h0)) begin
                bad++;
                $display("FAIL incdec step %0d: MUX=%h valid=%b wrap=%b zero=%b, want %h %b %b %b",
                         i, ifa.MUX, ifa.valid, ifa.wrap, ifa.zero, e.val, e.valid, e.wrap, (e.val == 24'h0));
            end
        end
    endtask

    task automatic test_bus();
        exp_t e;
        drive_op(2'b01, 2'd3, 24'h111111);
        e = sbq.pop_front(); ifa.mux_sel = e.sel; #1;
        total++;
        if (ifa.MUX !== e.val || ifa.valid !== e.valid) begin
            bad++;
            $display("FAIL bus_preload: MUX=%h valid=%b, want %h %b", ifa.MUX, ifa.valid, e.val, e.valid);
        end
        @(negedge clk);
        ifa.read_bus = 1'b1; ifa.bus_sel = 2'd3;
        ifa.op = 2'b01; ifa.wr_sel = 2'd3; ifa.data_in = 24'h123456;
        #1;
        total++;
        if (bus_a !== 24'h111111) begin
            bad++;
            $display("FAIL bus_same_cycle: BUS_OUT=%h, want 111111", bus_a);
        end
        m_regs[3] = 24'h123456; m_valid[3] = 1'b1;
        @(posedge clk); #1;
        ifa.op = 2'b00; #1;
        total++;
        if (bus_a !== 24'h123456) begin
            bad++;
            $display("FAIL bus_after_edge: BUS_OUT=%h, want 123456", bus_a);
        end
        ifa.bus_sel = 2'd2; #1;
        total++;
        if (bus_a !== m_regs[2]) begin
            bad++;
            $display("FAIL bus_sel2: BUS_OUT=%h, want %h", bus_a, m_regs[2]);
        end
        ifa.read_bus = 1'b0; #1;
        total++;
        if (bus_a !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL bus_release: BUS_OUT=%h, want undriven (pulled to ffffff)", bus_a);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            drive_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 24'($urandom));
            e = sbq.pop_front(); ifa.mux_sel = e.sel; #1;
            total++;
            if (ifa.MUX !== e.val || ifa.valid !== e.valid || ifa.wrap !== e.wrap) begin
                bad++;
                $display("FAIL b2b %0d: MUX=%h valid=%b wrap=%b, want %h %b %b",
                         i, ifa.MUX, ifa.valid, ifa.wrap, e.val, e.valid, e.wrap);
            end
        end
        for (int s = 0; s < 4; s++) begin
            ifa.mux_sel = 2'(s); #1;
            total++;
            if (ifa.MUX !== m_regs[s]) begin
                bad++;
                $display("FAIL b2b_sweep reg%0d: MUX=%h, want %h", s, ifa.MUX, m_regs[s]);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive_op(2'b01, 2'd2, 24'h5A5A5A);
        e = sbq.pop_front(); ifa.mux_sel = e.sel; #1;
        total++;
        if (ifa.MUX !== e.val || ifa.valid !== e.valid) begin
            bad++;
            $display("FAIL areset_pre: MUX=%h valid=%b, want %h %b", ifa.MUX, ifa.valid, e.val, e.valid);
        end
        ifa.read_bus = 1'b1; ifa.bus_sel = 2'd2;
        @(negedge clk); #2;
        rst = 1'b1; #1;
        model_reset();
        total++;
        if (ifa.MUX !== 24'h0 || ifa.valid !== 4'b0000 || ifa.wrap !== 1'b0 || bus_a !== 24'h0) begin
            bad++;
            $display("FAIL areset_now: MUX=%h valid=%b wrap=%b BUS_OUT=%h, want 000000 0000 0 000000",
                     ifa.MUX, ifa.valid, ifa.wrap, bus_a);
        end
        ifa.read_bus = 1'b0;
        @(negedge clk);
        ifa.op = 2'b01; ifa.wr_sel = 2'd1; ifa.data_in = 24'h777777; ifa.mux_sel = 2'd1;
        @(posedge clk); #1;
        ifa.op = 2'b00; #1;
        total++;
        if (ifa.MUX !== 24'h0 || ifa.valid !== 4'b0000) begin
            bad++;
            $display("FAIL areset_edge_op: MUX=%h valid=%b, want 000000 0000", ifa.MUX, ifa.valid);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_op(2'b01, 2'd1, 24'h0C0C0C);
        e = sbq.pop_front(); ifa.mux_sel = e.sel; #1;
        total++;
        if (ifa.MUX !== 24'h0C0C0C || ifa.valid !== 4'b0010 || ifa.MUX !== e.val) begin
            bad++;
            $display("FAIL areset_first_op: MUX=%h valid=%b, want 0c0c0c 0010", ifa.MUX, ifa.valid);
        end
    endtask

    task automatic test_depth3();
        logic [23:0] want[3] = '{24'h0, 24'h0, 24'h000055};
        @(negedge clk);
        ifb.op = 2'b01; ifb.wr_sel = 2'd2; ifb.data_in = 24'h000055;
        @(negedge clk);
        ifb.op = 2'b01; ifb.wr_sel = 2'd3; ifb.data_in = 24'h0000AA;
        @(negedge clk);
        ifb.op = 2'b00;
        total++;
        if (ifb.valid[2:0] !== 3'b100 || ifb.wrap !== 1'b0) begin
            bad++;
            $display("FAIL depth3_valid: valid=%b wrap=%b, want 100 0", ifb.valid[2:0], ifb.wrap);
        end
        for (int s = 0; s < 3; s++) begin
            ifb.mux_sel = 2'(s); #1;
            total++;
            if (ifb.MUX !== want[s]) begin
                bad++;
                $display("FAIL depth3_reg%0d: MUX=%h, want %h", s, ifb.MUX, want[s]);
            end
        end
        ifb.mux_sel = 2'd3; #1;
        total++;
        if (ifb.MUX !== 24'h0 || ifb.zero !== 1'b1) begin
            bad++;
            $display("FAIL depth3_mux_oob: MUX=%h zero=%b, want 000000 1", ifb.MUX, ifb.zero);
        end
        ifb.read_bus = 1'b1; ifb.bus_sel = 2'd3; #1;
        total++;
        if (bus_b !== 24'h0) begin
            bad++;
            $display("FAIL depth3_bus_oob: BUS_OUT=%h, want 000000", bus_b);
        end
        ifb.read_bus = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_incdec();
        test_bus();
        test_back_to_back();
        test_async_reset();
        test_depth3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
